// File: rtl/decode_scan_pkg.sv
// decode_pkg: shared types and helpers for the decode_scan block.
//   W       default output width (2**N_DFLT)
//   mode_e  operating mode: direct decode or auto-scan
//   onehot  index -> one-hot vector, MAX_W wide; callers cast down to their width
package decode_pkg;

  localparam int unsigned N_DFLT = 3;
  localparam int unsigned W      = 2 ** N_DFLT;
  localparam int unsigned MAX_N  = 8;
  localparam int unsigned MAX_W  = 2 ** MAX_N;

  typedef enum logic {
    MODE_DECODE = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] sel);
    logic [MAX_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decode_scan_tick_div.sv
// tick_div: scan-step prescaler.
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low (counter -> 0)
//   run    count enable; the counter advances only while run=1
//   clr    synchronous clear to 0 (takes priority over run)
//   tick   combinational, high when run=1 and the counter is at DIV-1
module tick_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_d, cnt_q;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decode_scan.sv
// decode_scan: registered one-hot decoder with enable and auto-scan.
//   clk, rst_n  clock / asynchronous active-low reset
//   en          1: drive outputs; 0: all lines inactive, scan frozen
//   mode        0: y = onehot(x); 1: rotate active line through 0..last
//   x           direct select index
//   last        highest scan index
//   y           registered one-hot (inverted when ACT_LOW=1)
//   idx         registered index currently shown on y
//   wrap        one-cycle pulse on the last -> 0 scan step
module decode_scan
  import decode_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned DIV     = 4,
  parameter bit          ACT_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      x,
  input  logic [N-1:0]      last,
  output logic [2**N-1:0]   y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned OUT_W = 2 ** N;

  mode_e          mode_s;
  logic           run, clr, tick;
  logic [N-1:0]   idx_d, idx_q;
  logic           wrap_d, wrap_q;
  logic [OUT_W-1:0] y_d, y_q;

  assign mode_s = mode_e'(mode);
  assign run    = en && (mode_s == MODE_SCAN);
  assign clr    = en && (mode_s == MODE_DECODE);

  tick_div #(.DIV(DIV)) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (en) begin
      case (mode_s)
        MODE_DECODE: idx_d = x;
        MODE_SCAN: begin
          if (tick) begin
            // >= rather than == so a shrink of last below idx wraps on the next step
            if (idx_q >= last) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + N'(1);
            end
          end
        end
        default: idx_d = idx_q;
      endcase
    end
    // y is built from idx_d so y and idx change on the same edge
    y_d = (en ? OUT_W'(onehot(MAX_N'(idx_d))) : '0) ^ {OUT_W{ACT_LOW}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
      y_q    <= {OUT_W{ACT_LOW}};
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      y_q    <= y_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decode_scan.sv
module tb_decode_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, mode = 1'b0;
  logic [2:0] x = '0, last = '0;

  logic [7:0] y0, y1;
  logic [2:0] idx0, idx1;
  logic       wrap0, wrap1;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  string       phase = "init";

  // reference state per instance: [0] DIV=4 active-high, [1] DIV=1 active-low
  int m_idx[2], m_pre[2], m_wrap[2], m_y[2];
  int divs[2] = '{4, 1};
  int act[2]  = '{0, 1};

  always #5 clk = ~clk;

  decode_scan #(.N(3), .DIV(4), .ACT_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x), .last(last),
    .y(y0), .idx(idx0), .wrap(wrap0)
  );

  decode_scan #(.N(3), .DIV(1), .ACT_LOW(1'b1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x), .last(last),
    .y(y1), .idx(idx1), .wrap(wrap1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_pre[k] = 0; m_wrap[k] = 0;
      m_y[k] = act[k] ? 255 : 0;
    end
  endtask

  // Behavioural rules: line index advances once per DIV enabled scan clocks,
  // wraps to 0 once it has reached or passed last.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_idx[k] = 0; m_pre[k] = 0; m_wrap[k] = 0;
      end else if (!en) begin
        m_wrap[k] = 0;
      end else if (!mode) begin
        m_idx[k] = int'(x); m_pre[k] = 0; m_wrap[k] = 0;
      end else if (m_pre[k] == divs[k] - 1) begin
        m_pre[k] = 0;
        if (m_idx[k] >= int'(last)) begin m_idx[k] = 0; m_wrap[k] = 1; end
        else begin m_idx[k] = m_idx[k] + 1; m_wrap[k] = 0; end
      end else begin
        m_pre[k] = m_pre[k] + 1; m_wrap[k] = 0;
      end
      m_y[k] = ((rst_n && en) ? (1 << m_idx[k]) : 0) ^ (act[k] ? 255 : 0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("y0", y0, m_y[0]);   chk("idx0", idx0, m_idx[0]); chk("wrap0", wrap0, m_wrap[0]);
    chk("y1", y1, m_y[1]);   chk("idx1", idx1, m_idx[1]); chk("wrap1", wrap1, m_wrap[1]);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // advance until the slow instance shows index target; a timeout is a failure
  task automatic wait_idx0(input int target, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      cyc();
      if (m_idx[0] == target) found = 1'b1;
    end
    compared++;
    assert (found) else begin
      mismatched++;
      $error("FAIL %s/wait_idx%0d: got timeout expected reached", phase, target);
    end
  endtask

  initial begin
    bit seen;
    model_reset();
    #12;
    phase = "reset_hold";
    #1;
    chk("y0", y0, 32'h00); chk("y1", y1, 32'hFF); chk("idx0", idx0, 0); chk("wrap0", wrap0, 0);
    rst_n = 1'b1;

    // direct decode
    phase = "direct";
    en = 1'b1; mode = 1'b0; x = 3'd5;
    cyc();
    chk("x5_y", y0, 32'h20); chk("x5_idx", idx0, 5);
    en = 1'b0;
    cyc();
    chk("en0_y", y0, 32'h00); chk("en0_y_low", y1, 32'hFF); chk("en0_idx", idx0, 5);
    en = 1'b1; x = 3'd0;
    cyc();
    chk("actlow_x0", y1, 32'hFE);
    for (int i = 0; i < 12; i++) begin
      x = 3'($urandom_range(0, 7)); en = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // async reset mid-cycle, no clock edge needed
    phase = "async_reset";
    en = 1'b1; mode = 1'b0; x = 3'd6;
    cyc();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("y0", y0, 32'h00); chk("idx0", idx0, 0); chk("wrap0", wrap0, 0); chk("y1", y1, 32'hFF);
    run_cycles(2);
    rst_n = 1'b1;

    // full scan 0..7 from idx 0
    phase = "scan_full";
    en = 1'b1; mode = 1'b0; x = 3'd0;
    cyc();
    mode = 1'b1; last = 3'd7;
    cyc();
    chk("fast_step1", idx1, 1);
    run_cycles(4 * 8 + 6);

    // short scan
    phase = "scan_short";
    last = 3'd2;
    run_cycles(4 * 7);

    // shrink last below current index
    phase = "shrink";
    last = 3'd7;
    wait_idx0(5, 60);
    last = 3'd3;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cyc();
      if (wrap0) begin
        seen = 1'b1;
        chk("shrink_idx", idx0, 0);
      end
    end
    compared++;
    assert (seen) else begin
      mismatched++;
      $error("FAIL %s/shrink_wrap: got no wrap expected wrap within 6 clk", phase);
    end

    // last = 0: wrap every tick
    phase = "last0";
    last = 3'd0;
    run_cycles(12);

    // pause at idx 3 and resume
    phase = "pause";
    last = 3'd7;
    wait_idx0(3, 60);
    en = 1'b0;
    run_cycles(10);
    chk("hold_idx", idx0, 3); chk("hold_y", y0, 32'h00);
    en = 1'b1;
    cyc();
    chk("resume_idx", idx0, 3); chk("resume_y", y0, 32'h08);
    run_cycles(9);

    // back to direct decode
    phase = "mode_1to0";
    mode = 1'b0; x = 3'd6;
    cyc();
    chk("x6_y", y0, 32'h40); chk("x6_wrap", wrap0, 0); chk("x6_y_low", y1, 32'hBF);

    // randomized mix
    phase = "random";
    for (int i = 0; i < 300; i++) begin
      en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      x    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) last = 3'($urandom_range(0, 7));
      cyc();
    end

    // reset mid-scan restarts from 0
    phase = "reset_scan";
    en = 1'b1; mode = 1'b1; last = 3'd7;
    run_cycles(7);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("idx0", idx0, 0); chk("y0", y0, 32'h00);
    run_cycles(1);
    rst_n = 1'b1;
    run_cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
